// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The ovf signal exists only when SUBTRACTOR_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             borrow_out;
`ifdef SUBTRACTOR_OVERFLOW_EN
  logic             ovf;

  modport master (
    output start, A, B,
    input  busy, done, D, borrow_out, ovf
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, borrow_out, ovf
  );
`else
  modport master (
    output start, A, B,
    input  busy, done, D, borrow_out
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, borrow_out
  );
`endif
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor D = A - B: one full-subtractor cell and a borrow flop.
// Optional signed-overflow output enabled by defining SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             br_q,     br_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bo_q,     bo_d;
`ifdef SUBTRACTOR_OVERFLOW_EN
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic             ovf_q,    ovf_d;
`endif

  // Full-subtractor cell on the current LSBs
  logic a_bit, b_bit, d_bit, br_next;
  logic accept;

  always_comb begin
    a_bit   = a_sr_q[0];
    b_bit   = b_sr_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    accept  = bus.start && (state_q != S_SHIFT);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SUBTRACTOR_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_sr_d  = bus.A;
          b_sr_d  = bus.B;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef SUBTRACTOR_OVERFLOW_EN
          a_msb_d = bus.A[WIDTH-1];
          b_msb_d = bus.B[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        // Publish on the last bit so D is already valid during the DONE cycle
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = res_d;
          bo_d    = br_next;
`ifdef SUBTRACTOR_OVERFLOW_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so an aborted operation leaves D at zero.
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
`ifdef SUBTRACTOR_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.D          = diff_q;
  assign bus.borrow_out = bo_q;
`ifdef SUBTRACTOR_OVERFLOW_EN
  assign bus.ovf        = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    longint r;
    r = (longint'(a) - longint'(b) + (longint'(1) << W)) % (longint'(1) << W);
    return r[W-1:0];
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    return a < b;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sa - sb;
    return (r > (longint'(1) << (W - 1)) - 1) || (r < -(longint'(1) << (W - 1)));
  endfunction

  // Issue one operation and check every cycle up to and including DONE.
  // Returns positioned at the falling edge inside the DONE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit poke);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.start = 1'b0;
      bus.A     = W'($urandom);
      bus.B     = W'($urandom);
    end
    for (int i = 0; i < W; i++) begin
      if (poke && i == 2) begin
        bus.start = 1'b1;
        bus.A     = '1;
        bus.B     = '1;
      end
      if (poke && i == 3) bus.start = 1'b0;
      @(negedge clk);
      check($sformatf("busy_c%0d", i), 32'(bus.busy), 32'd1);
      check($sformatf("nodone_c%0d", i), 32'(bus.done), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_in_done", 32'(bus.busy), 32'd0);
    check($sformatf("D_%0h_%0h", a, b), 32'(bus.D), 32'(ref_diff(a, b)));
    check($sformatf("borrow_%0h_%0h", a, b), 32'(bus.borrow_out), 32'(ref_borrow(a, b)));
`ifdef SUBTRACTOR_OVERFLOW_EN
    check($sformatf("ovf_%0h_%0h", a, b), 32'(bus.ovf), 32'(ref_ovf(a, b)));
`endif
  endtask

  // One cycle after DONE with start low: back to idle, results held
  task automatic idle_after(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("D_held", 32'(bus.D), 32'(ref_diff(a, b)));
    check("borrow_held", 32'(bus.borrow_out), 32'(ref_borrow(a, b)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_D"}, 32'(bus.D), 32'd0);
    check({tag, "_borrow"}, 32'(bus.borrow_out), 32'd0);
`ifdef SUBTRACTOR_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rh;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_release");

    // Directed cases
    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    idle_after(8'h05, 8'h03);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    idle_after(8'h00, 8'h01);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    idle_after(8'h80, 8'h01);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    idle_after(8'hFF, 8'hFF);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    idle_after(8'h7F, 8'hFF);

    // start during SHIFT is ignored; exactly one done
    run_op(8'h10, 8'h01, 1'b0, 1'b1);
    idle_after(8'h10, 8'h01);
    @(negedge clk);
    check("no_second_done", 32'(bus.done), 32'd0);

    // start held high: results back-to-back every W+1 cycles
    for (int k = 0; k < 3; k++) run_op(8'hAA, 8'h55, 1'b1, 1'b0);
    bus.start = 1'b0;
    idle_after(8'hAA, 8'h55);

    // Reset in the fourth SHIFT cycle aborts the operation
    bus.start = 1'b1;
    bus.A     = 8'h10;
    bus.B     = 8'h01;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("abort_done_c%0d", i), 32'(bus.done), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check($sformatf("post_abort_done_c%0d", i), 32'(bus.done), 32'd0);
      check($sformatf("post_abort_D_c%0d", i), 32'(bus.D), 32'd0);
    end
    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    idle_after(8'h05, 8'h03);

    // Randomized operations, some chained back-to-back
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rh = 1'($urandom_range(0, 1));
      run_op(ra, rb, rh, 1'b0);
      if (!rh) idle_after(ra, rb);
    end
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("final_idle_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_subtractor
